// File: rtl/camera_init_ctrl.sv
// Camera power-up sequencer: XCLK divider, power/reset sequencing, SCCB config
// handshake, frame-skip settling, per-attempt timeout with bounded retries.
module camera_init_ctrl #(
  parameter int unsigned DIV_HALF       = 1,
  parameter int unsigned PWR_CYCLES     = 50000,
  parameter int unsigned SKIP_FRAMES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic                           clk_in_50,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           reinit,
  input  logic                           frame_done,
  input  logic                           cfg_done,
  output logic                           clk_camera,
  output logic                           cam_reset_n,
  output logic                           cam_pwdn,
  output logic                           cfg_start,
  output logic                           init_finish,
  output logic                           init_error,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  localparam int unsigned DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam int unsigned PW = (PWR_CYCLES > 1) ? $clog2(PWR_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned FW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

  localparam int unsigned DIV_LAST = DIV_HALF - 1;
  localparam int unsigned PWR_LAST = PWR_CYCLES - 1;
  localparam int unsigned TO_LAST  = TIMEOUT_CYCLES - 1;
  localparam int unsigned FRM_LAST = (SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PWR    = 3'd1;
  localparam logic [2:0] S_CFG    = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_READY  = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  logic [2:0]    state, state_d;
  logic [RW-1:0] retry_d;
  logic [DW-1:0] div_cnt;
  logic [PW-1:0] pwr_cnt;
  logic [TW-1:0] to_cnt;
  logic [FW-1:0] frm_cnt;
  logic [2:0]    fd_sync;
  logic          frame_evt;
  logic          pwr_clr, to_clr, frm_clr, to_hit, success;
  logic          pwdn_d, rstn_d, cfg_start_d, finish_d, error_d;

  // Free-running XCLK divider
  always_ff @(posedge clk_in_50 or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      clk_camera <= 1'b0;
    end else if (div_cnt == DW'(DIV_LAST)) begin
      div_cnt    <= '0;
      clk_camera <= ~clk_camera;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Two-flop synchroniser plus edge detect; frame_evt lands 3 edges after input
  always_ff @(posedge clk_in_50 or negedge rst_n) begin
    if (!rst_n) begin
      fd_sync   <= '0;
      frame_evt <= 1'b0;
    end else begin
      fd_sync   <= {fd_sync[1:0], frame_done};
      frame_evt <= fd_sync[1] & ~fd_sync[2];
    end
  end

  // Next-state and registered-output next values
  always_comb begin
    state_d = state;
    retry_d = retry_cnt;
    pwr_clr = 1'b0;
    to_clr  = 1'b0;
    frm_clr = 1'b0;
    success = 1'b0;
    to_hit  = (to_cnt == TW'(TO_LAST));

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_PWR;
          pwr_clr = 1'b1;
        end
      end
      S_PWR: begin
        if (pwr_cnt == PW'(PWR_LAST)) begin
          state_d = S_CFG;
          to_clr  = 1'b1;
        end
      end
      S_CFG: begin
        // cfg_start is high only on the first CONFIG cycle, which masks cfg_done there
        if (!cfg_start && cfg_done) begin
          state_d = S_SETTLE;
          frm_clr = 1'b1;
          success = 1'b1;
        end
      end
      S_SETTLE: begin
        if ((SKIP_FRAMES == 0) || (frame_evt && (frm_cnt == FW'(FRM_LAST)))) begin
          state_d = S_READY;
          success = 1'b1;
        end
      end
      S_READY: state_d = S_READY;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    // Timeout loses to a same-cycle success
    if ((state == S_CFG || state == S_SETTLE) && to_hit && !success) begin
      if (retry_cnt < RW'(MAX_RETRY)) begin
        retry_d = retry_cnt + 1'b1;
        state_d = S_PWR;
        pwr_clr = 1'b1;
      end else begin
        state_d = S_ERROR;
      end
    end

    if (reinit && state != S_IDLE) begin
      state_d = S_PWR;
      retry_d = '0;
      pwr_clr = 1'b1;
    end

    pwdn_d      = (state_d == S_IDLE) || (state_d == S_ERROR);
    rstn_d      = (state_d == S_CFG) || (state_d == S_SETTLE) || (state_d == S_READY);
    cfg_start_d = (state_d == S_CFG) && (state != S_CFG);
    finish_d    = (state_d == S_READY);
    error_d     = (state_d == S_ERROR);
  end

  always_ff @(posedge clk_in_50 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      retry_cnt   <= '0;
      cam_pwdn    <= 1'b1;
      cam_reset_n <= 1'b0;
      cfg_start   <= 1'b0;
      init_finish <= 1'b0;
      init_error  <= 1'b0;
    end else begin
      state       <= state_d;
      retry_cnt   <= retry_d;
      cam_pwdn    <= pwdn_d;
      cam_reset_n <= rstn_d;
      cfg_start   <= cfg_start_d;
      init_finish <= finish_d;
      init_error  <= error_d;
    end
  end

  // Phase counters; the timeout counter saturates once the budget is spent
  always_ff @(posedge clk_in_50 or negedge rst_n) begin
    if (!rst_n) begin
      pwr_cnt <= '0;
      to_cnt  <= '0;
      frm_cnt <= '0;
    end else begin
      if (pwr_clr)              pwr_cnt <= '0;
      else if (state == S_PWR)  pwr_cnt <= pwr_cnt + 1'b1;

      if (to_clr)                                               to_cnt <= '0;
      else if ((state == S_CFG || state == S_SETTLE) && !to_hit) to_cnt <= to_cnt + 1'b1;

      if (frm_clr)                             frm_cnt <= '0;
      else if (state == S_SETTLE && frame_evt) frm_cnt <= frm_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_camera_init_ctrl.sv
// Directed bench for camera_init_ctrl: vector table for the normal flow plus
// hand-written retry, recovery, boundary and reset sequences.
module tb_camera_init_ctrl;

  logic clk_in_50, rst_n, start, reinit, frame_done, cfg_done;
  logic clk_camera, cam_reset_n, cam_pwdn, cfg_start, init_finish, init_error;
  logic [0:0] retry_cnt;
  logic clk_camera0, cam_reset_n0, cam_pwdn0, cfg_start0, init_finish0, init_error0;
  logic [0:0] retry_cnt0;

  int tests = 0;
  int fails = 0;

  camera_init_ctrl #(.DIV_HALF(2), .PWR_CYCLES(4), .SKIP_FRAMES(2),
                     .TIMEOUT_CYCLES(20), .MAX_RETRY(1)) u_dut (
    .clk_in_50(clk_in_50), .rst_n(rst_n), .start(start), .reinit(reinit),
    .frame_done(frame_done), .cfg_done(cfg_done), .clk_camera(clk_camera),
    .cam_reset_n(cam_reset_n), .cam_pwdn(cam_pwdn), .cfg_start(cfg_start),
    .init_finish(init_finish), .init_error(init_error), .retry_cnt(retry_cnt));

  camera_init_ctrl #(.DIV_HALF(2), .PWR_CYCLES(4), .SKIP_FRAMES(0),
                     .TIMEOUT_CYCLES(20), .MAX_RETRY(1)) u_dut0 (
    .clk_in_50(clk_in_50), .rst_n(rst_n), .start(start), .reinit(reinit),
    .frame_done(frame_done), .cfg_done(cfg_done), .clk_camera(clk_camera0),
    .cam_reset_n(cam_reset_n0), .cam_pwdn(cam_pwdn0), .cfg_start(cfg_start0),
    .init_finish(init_finish0), .init_error(init_error0), .retry_cnt(retry_cnt0));

  initial clk_in_50 = 1'b0;
  always #5 clk_in_50 = ~clk_in_50;

  // exp packs {pwdn, reset_n, cfg_start, finish, error, retry}
  typedef struct {
    logic       start;
    logic       reinit;
    logic       cfg_done;
    logic       frame_done;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic s, logic r, logic c, logic f, logic [5:0] e);
    vec_t v;
    v.start = s; v.reinit = r; v.cfg_done = c; v.frame_done = f; v.exp = e;
    return v;
  endfunction

  function automatic logic [5:0] outs();
    return {cam_pwdn, cam_reset_n, cfg_start, init_finish, init_error, retry_cnt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in_50);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; reinit = 1'b0; frame_done = 1'b0; cfg_done = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      start      = tbl[i].start;
      reinit     = tbl[i].reinit;
      cfg_done   = tbl[i].cfg_done;
      frame_done = tbl[i].frame_done;
      step();
      chk($sformatf("row%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
  endtask

  initial begin
    logic [5:0] clk_exp;
    tbl[0]  = mk(0, 1, 0, 0, 6'b100000);  // reinit ignored in IDLE
    tbl[1]  = mk(1, 0, 0, 0, 6'b000000);  // PWR_WAIT 1
    tbl[2]  = mk(1, 0, 0, 0, 6'b000000);
    tbl[3]  = mk(1, 0, 0, 0, 6'b000000);
    tbl[4]  = mk(1, 0, 0, 0, 6'b000000);  // PWR_WAIT 4
    tbl[5]  = mk(1, 0, 0, 0, 6'b011000);  // CONFIG 1, cfg_start pulse
    tbl[6]  = mk(1, 0, 0, 0, 6'b010000);
    tbl[7]  = mk(1, 0, 0, 0, 6'b010000);  // CONFIG 3
    tbl[8]  = mk(1, 0, 1, 0, 6'b010000);  // cfg_done during CONFIG 3 -> SETTLE
    tbl[9]  = mk(1, 0, 1, 1, 6'b010000);
    tbl[10] = mk(1, 0, 1, 1, 6'b010000);
    tbl[11] = mk(1, 0, 1, 0, 6'b010000);
    tbl[12] = mk(1, 0, 1, 0, 6'b010000);
    tbl[13] = mk(1, 0, 1, 1, 6'b010000);  // second frame pulse
    tbl[14] = mk(1, 0, 1, 1, 6'b010000);
    tbl[15] = mk(1, 0, 1, 0, 6'b010000);
    tbl[16] = mk(1, 0, 1, 0, 6'b010100);  // READY 4 edges after the pulse
    tbl[17] = mk(0, 0, 0, 0, 6'b010100);

    rst_n = 1'b1; start = 1'b0; reinit = 1'b0; frame_done = 1'b0; cfg_done = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_outs", 32'(outs()), 32'(6'b100000));
    chk("reset_xclk", 32'(clk_camera), 32'(0));
    step();
    step();
    rst_n = 1'b1;

    // XCLK: period 4, first rise 2 edges after release
    clk_exp = 6'b100110;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("xclk%0d", i), 32'(clk_camera), 32'(clk_exp[i]));
    end

    run_rows(0, 17);

    // Retry then error with cfg_done held low
    do_reset();
    start = 1'b1;
    step();
    for (int i = 0; i < 3; i++) step();
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("try1_cfg%0d", i), 32'({cam_reset_n, retry_cnt}), 32'(2'b10));
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("retry_pwr%0d", i), 32'({cam_reset_n, retry_cnt}), 32'(2'b01));
    end
    step();
    chk("try2_cfg_start", 32'(outs()), 32'(6'b011001));
    for (int i = 0; i < 19; i++) step();
    chk("try2_last_cfg", 32'(outs()), 32'(6'b010001));
    step();
    chk("error_state", 32'(outs()), 32'(6'b100011));
    step();
    chk("error_hold", 32'(outs()), 32'(6'b100011));

    // Recovery from ERROR via reinit
    start = 1'b0;
    reinit = 1'b1;
    step();
    reinit = 1'b0;
    chk("reinit_clear", 32'(outs()), 32'(6'b000000));
    run_rows(2, 17);

    // cfg_done first seen on the timeout cycle: success wins
    do_reset();
    start = 1'b1;
    step();
    for (int i = 0; i < 3; i++) step();
    step();
    for (int i = 0; i < 19; i++) step();
    chk("to_cfg20", 32'({cam_reset_n, retry_cnt}), 32'(2'b10));
    cfg_done = 1'b1;
    step();
    chk("to_success", 32'(outs()), 32'(6'b010000));
    chk("skip0_settle", 32'(init_finish0), 32'(0));
    step();
    chk("skip0_ready", 32'({init_finish0, retry_cnt0}), 32'(2'b10));

    // cfg_done masked on the first CONFIG cycle, then reset in SETTLE
    do_reset();
    start = 1'b1;
    step();
    for (int i = 0; i < 3; i++) step();
    step();
    cfg_done = 1'b1;
    chk("cfg1_start", 32'(cfg_start), 32'(1));
    step();
    step();
    chk("cfg1_masked", 32'(init_finish0), 32'(0));
    step();
    chk("cfg2_settle_ready0", 32'(init_finish0), 32'(1));
    chk("settle_outs", 32'(outs()), 32'(6'b010000));
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'(outs()), 32'(6'b100000));
    chk("async_reset_xclk", 32'(clk_camera), 32'(0));
    chk("async_reset_dut0", 32'(init_finish0), 32'(0));
    start = 1'b0; cfg_done = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("idle_no_start", 32'(outs()), 32'(6'b100000));
    start = 1'b1;
    step();
    chk("start_again", 32'(outs()), 32'(6'b000000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/camera_init_ctrl.md
CAMERA_INIT_CTRL -- requirements
Module: camera_init_ctrl

Interface
REQ-001 The module SHALL have parameter DIV_HALF, default 1, meaning clk_in_50 cycles per clk_camera half-period, legal range 1 or more.
REQ-002 The module SHALL have parameter PWR_CYCLES, default 50000, meaning cam_reset_n low time in clk_in_50 cycles, legal range 1 or more.
REQ-003 The module SHALL have parameter SKIP_FRAMES, default 2, meaning frames discarded after configuration before READY, legal range 0 or more.
REQ-004 The module SHALL have parameter TIMEOUT_CYCLES, default 5000000, meaning maximum cycles spent in CONFIG plus SETTLE per attempt.
REQ-005 The module SHALL have parameter MAX_RETRY, default 3, meaning extra attempts after the first timeout.
REQ-006 The module SHALL have port clk_in_50, input, 1 bit: the single system clock; all logic runs on its rising edge.
REQ-007 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The module SHALL have port start, input, 1 bit: level request to begin initialisation.
REQ-009 The module SHALL have port reinit, input, 1 bit: single-cycle request to restart initialisation.
REQ-010 The module SHALL have port frame_done, input, 1 bit: camera frame-end strobe, asynchronous to clk_in_50.
REQ-011 The module SHALL have port cfg_done, input, 1 bit: level from the SCCB register loader indicating the table is written.
REQ-012 The module SHALL have port clk_camera, output, 1 bit: divided camera XCLK.
REQ-013 The module SHALL have port cam_reset_n, output, 1 bit: camera hardware reset.
REQ-014 The module SHALL have port cam_pwdn, output, 1 bit: camera power-down.
REQ-015 The module SHALL have port cfg_start, output, 1 bit: one-cycle pulse that starts the SCCB loader.
REQ-016 The module SHALL have port init_finish, output, 1 bit: camera configured and stream valid.
REQ-017 The module SHALL have port init_error, output, 1 bit: all attempts failed; sticky.
REQ-018 The module SHALL have port retry_cnt, output, width clog2(MAX_RETRY+1): the number of retries used.

Function
REQ-019 clk_camera SHALL toggle when a free-running counter (range 0..DIV_HALF-1) reaches DIV_HALF-1; the divider SHALL run in every state.
REQ-020 frame_done SHALL pass through a 2-flop synchroniser; the rising edge of the synchronised signal SHALL produce a one-cycle frame_evt, giving 3 cycles of latency from input.
REQ-021 The FSM SHALL have states IDLE, PWR_WAIT, CONFIG, SETTLE, READY and ERROR.
REQ-022 IDLE: cam_pwdn=1 and cam_reset_n=0; when start=1 the FSM SHALL move to PWR_WAIT.
REQ-023 PWR_WAIT: cam_pwdn=0 and cam_reset_n=0 for exactly PWR_CYCLES cycles, then the FSM SHALL move to CONFIG.
REQ-024 CONFIG: cam_reset_n=1, and cfg_start=1 on the first cycle only; cfg_done SHALL be ignored on that first cycle; cfg_done=1 afterwards SHALL move the FSM to SETTLE.
REQ-025 SETTLE: the FSM SHALL count frame_evt and move to READY when the count equals SKIP_FRAMES; if SKIP_FRAMES=0, it SHALL move to READY on the next cycle.
REQ-026 The timeout counter SHALL clear on entry to CONFIG and run through CONFIG and SETTLE; on reaching TIMEOUT_CYCLES with retry_cnt<MAX_RETRY, the FSM SHALL increment retry_cnt and go to PWR_WAIT.
REQ-027 On reaching TIMEOUT_CYCLES with retry_cnt=MAX_RETRY, the FSM SHALL go to ERROR.
REQ-028 If timeout and cfg_done or the final frame_evt occur in the same cycle, success SHALL win.
REQ-029 READY: init_finish SHALL be a registered 1 and the FSM SHALL hold there.
REQ-030 ERROR: init_error=1, cam_pwdn=1, cam_reset_n=0, and the FSM SHALL hold there.
REQ-031 reinit=1 in any state other than IDLE SHALL take priority: clear retry_cnt, clear init_error and init_finish on the next edge, and go to PWR_WAIT.
REQ-032 reinit in IDLE SHALL be ignored, and start outside IDLE SHALL be ignored.

Reset
REQ-033 When rst_n=0, the module SHALL asynchronously force: state=IDLE, clk_camera=0, cam_pwdn=1, cam_reset_n=0, cfg_start=0, init_finish=0, init_error=0, retry_cnt=0, and all counters and synchroniser flops to 0.
REQ-034 Reset deassertion SHALL take effect on the next clk_in_50 edge; assertion mid-operation SHALL abort immediately with no cfg_start glitch.

Verification
Common parameters: DIV_HALF=2, PWR_CYCLES=4, SKIP_FRAMES=2, TIMEOUT_CYCLES=20, MAX_RETRY=1.
REQ-035 Clock check: release rst_n -> clk_camera has period 4 clk_in_50 cycles, first rising edge 2 cycles after reset release.
REQ-036 Normal flow: start=1, cfg_done=1 on the 3rd CONFIG cycle, two frame_done pulses -> cam_reset_n rises after 4 cycles, cfg_start is a single 1-cycle pulse, init_finish=1 3 or 4 cycles after the 2nd pulse, retry_cnt=0.
REQ-037 Retry: cfg_done held 0 -> first timeout gives retry_cnt=1 and cam_reset_n=0 for 4 cycles; second timeout gives init_error=1 with init_finish=0.
REQ-038 Recovery: reinit pulse while in ERROR -> init_error=0 and retry_cnt=0 next cycle; a normal flow then reaches init_finish=1.
REQ-039 Boundary: cfg_done rising on the timeout cycle -> FSM enters SETTLE and retry_cnt is unchanged; separately, with SKIP_FRAMES=0, READY is reached 1 cycle after SETTLE entry.
REQ-040 Reset while in SETTLE -> all outputs return to their reset values with no clock edge needed, and start is required again.
